ctrl_bubble_stage: RTL and testbench
====================================

Name: ctrl_bubble_stage

Overview:
- Parametrised ID/EX control pipeline register with bubble injection.
- Captures the EX/MEM/WB control bundles from decode each cycle and presents them registered to EX.
- Replaces them with a zero bubble on hazard stall or branch flush. Flushes can extend over several cycles.
- Stall behaviour is configurable: inject a bubble, or hold the current contents.
- Keeps a saturating count of injected bubbles for performance debug.

Parameters:
- EX_W, 2, width of EX control bundle
- MEM_W, 3, width of MEM control bundle
- WB_W, 2, width of WB control bundle
- FLUSH_CYCLES, 1, number of consecutive bubble cycles per flush request (legal range 1..15)
- STALL_MODE, 0, 0 = stall injects bubble; 1 = stall holds current outputs
- CNT_W, 16, width of bubble counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- stall_i  in  1  hazard-unit stall request
- flush_i  in  1  branch/jump flush request
- valid_i  in  1  decode slot holds a real instruction
- EX_signal_i  in  EX_W  EX control from decode
- MEM_signal_i  in  MEM_W  MEM control from decode
- WB_signal_i  in  WB_W  WB control from decode
- EX_signal_o  out  EX_W  registered EX control
- MEM_signal_o  out  MEM_W  registered MEM control
- WB_signal_o  out  WB_W  registered WB control
- valid_o  out  1  registered slot valid
- bubble_o  out  1  registered; 1 when current outputs are an injected bubble
- flush_busy_o  out  1  multi-cycle flush still in progress (combinational from counter)
- bubble_cnt_o  out  CNT_W  saturating count of injected bubbles

Behaviour:
- Reset (rst_i=1, asynchronous):
  - all control outputs 0; valid_o=0; bubble_o=0
  - flush counter fcnt=0; bubble_cnt_o=0
  - Reset mid-flush aborts the flush immediately.
- All outputs are registered; latency is 1 cycle from input to output.
- Per-edge priority: flush_i > fcnt!=0 > stall_i > normal load.
- flush_i=1:
  - load bubble: control outputs 0, valid_o=0, bubble_o=1
  - fcnt <= FLUSH_CYCLES-1
  - A flush during an active flush reloads fcnt (restarts the window; no accumulation).
- fcnt!=0 and flush_i=0:
  - load bubble; fcnt <= fcnt-1
  - stall_i is ignored while the flush is active.
- stall_i=1, no flush active:
  - STALL_MODE=0: load bubble.
  - STALL_MODE=1: all outputs, including valid_o and bubble_o, keep their values. This is not counted as a bubble.
- Normal load: outputs <= inputs; valid_o <= valid_i; bubble_o <= 0.
  - valid_i=0 with no stall/flush still passes the inputs through. bubble_o=0 because this is not an injected bubble.
- Bubble encoding is all-zero. Never X.
- flush_busy_o = (fcnt != 0).
- bubble_cnt_o:
  - increments by 1 on each edge that loads an injected bubble
  - saturates at 2^CNT_W-1; no wrap
- fcnt width is 4 bits.
- FLUSH_CYCLES=1 gives a single-cycle flush, identical to a one-shot bubble.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle while outputs are nonzero. Required: outputs, valid_o, bubble_o and bubble_cnt_o go to 0 before the next edge.
- Normal flow: EX=2'b10, MEM=3'b101, WB=2'b11, valid_i=1, no stall/flush. Required: same values on outputs 1 cycle later; valid_o=1; bubble_o=0; bubble_cnt_o=0.
- Stall, STALL_MODE=0: stall_i=1 for 1 cycle with nonzero inputs. Required: next cycle outputs 0, valid_o=0, bubble_o=1, bubble_cnt_o=1. Inputs pass through again the following cycle.
- Stall, STALL_MODE=1: outputs hold EX=2'b01 through 3 stall cycles. Required: outputs stay 2'b01 and bubble_cnt_o stays 0.
- Multi-cycle flush, FLUSH_CYCLES=3: one-cycle flush_i pulse, with stall_i=1 on the second cycle. Required: exactly 3 bubble cycles; flush_busy_o high for 2 cycles; bubble_cnt_o=3; normal load on the 4th cycle.
- Flush reload and saturation, CNT_W=2, FLUSH_CYCLES=3: flush_i at t0 and again at t2. Required: bubbles from t0 through t4 (5 cycles). bubble_cnt_o saturates at 3 and does not wrap.

Source files
------------

// File: rtl/ctrl_bubble_stage.sv
// ID/EX control pipeline register that replaces decode control with an all-zero bubble
// on stall or (possibly multi-cycle) flush, and counts injected bubbles.
module ctrl_bubble_stage #(
    parameter int unsigned EX_W         = 2,
    parameter int unsigned MEM_W        = 3,
    parameter int unsigned WB_W         = 2,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned STALL_MODE   = 0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [EX_W-1:0]  EX_signal_i,
    input  logic [MEM_W-1:0] MEM_signal_i,
    input  logic [WB_W-1:0]  WB_signal_i,
    output logic [EX_W-1:0]  EX_signal_o,
    output logic [MEM_W-1:0] MEM_signal_o,
    output logic [WB_W-1:0]  WB_signal_o,
    output logic             valid_o,
    output logic             bubble_o,
    output logic             flush_busy_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    localparam logic [3:0] FlushReload = 4'(FLUSH_CYCLES - 1);

    logic [EX_W-1:0]  ex_q, ex_d;
    logic [MEM_W-1:0] mem_q, mem_d;
    logic [WB_W-1:0]  wb_q, wb_d;
    logic             valid_q, valid_d;
    logic             bubble_q, bubble_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inject;

    always_comb begin
        ex_d     = ex_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        valid_d  = valid_q;
        bubble_d = bubble_q;
        fcnt_d   = fcnt_q;
        cnt_d    = cnt_q;
        inject   = 1'b0;

        // Flush outranks an active flush window, which outranks stall.
        if (flush_i) begin
            inject = 1'b1;
            fcnt_d = FlushReload;
        end else if (fcnt_q != 4'd0) begin
            inject = 1'b1;
            fcnt_d = fcnt_q - 4'd1;
        end else if (stall_i) begin
            inject = (STALL_MODE == 0);
        end else begin
            ex_d     = EX_signal_i;
            mem_d    = MEM_signal_i;
            wb_d     = WB_signal_i;
            valid_d  = valid_i;
            bubble_d = 1'b0;
        end

        if (inject) begin
            ex_d     = '0;
            mem_d    = '0;
            wb_d     = '0;
            valid_d  = 1'b0;
            bubble_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            valid_q  <= 1'b0;
            bubble_q <= 1'b0;
            fcnt_q   <= 4'd0;
            cnt_q    <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            valid_q  <= valid_d;
            bubble_q <= bubble_d;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign EX_signal_o  = ex_q;
    assign MEM_signal_o = mem_q;
    assign WB_signal_o  = wb_q;
    assign valid_o      = valid_q;
    assign bubble_o     = bubble_q;
    assign flush_busy_o = (fcnt_q != 4'd0);
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Bench for ctrl_bubble_stage: three configurations share one stimulus stream and are each
// compared against a remaining-bubbles reference model.
module tb_ctrl_bubble_stage;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       stall_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [1:0] ex_i = '0;
    logic [2:0] mem_i = '0;
    logic [1:0] wb_i = '0;

    always #5 clk_i = ~clk_i;

    // Instance 0: defaults; 1: hold-on-stall, 3-cycle flush; 2: 3-cycle flush, 2-bit counter.
    logic [1:0]  ex_o   [3];
    logic [2:0]  mem_o  [3];
    logic [1:0]  wb_o   [3];
    logic        v_o    [3];
    logic        b_o    [3];
    logic        busy_o [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;
    logic [25:0] obs    [3];

    ctrl_bubble_stage u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .EX_signal_i(ex_i), .MEM_signal_i(mem_i), .WB_signal_i(wb_i),
        .EX_signal_o(ex_o[0]), .MEM_signal_o(mem_o[0]), .WB_signal_o(wb_o[0]),
        .valid_o(v_o[0]), .bubble_o(b_o[0]), .flush_busy_o(busy_o[0]), .bubble_cnt_o(cnt0)
    );

    ctrl_bubble_stage #(.FLUSH_CYCLES(3), .STALL_MODE(1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .EX_signal_i(ex_i), .MEM_signal_i(mem_i), .WB_signal_i(wb_i),
        .EX_signal_o(ex_o[1]), .MEM_signal_o(mem_o[1]), .WB_signal_o(wb_o[1]),
        .valid_o(v_o[1]), .bubble_o(b_o[1]), .flush_busy_o(busy_o[1]), .bubble_cnt_o(cnt1)
    );

    ctrl_bubble_stage #(.FLUSH_CYCLES(3), .CNT_W(2)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .EX_signal_i(ex_i), .MEM_signal_i(mem_i), .WB_signal_i(wb_i),
        .EX_signal_o(ex_o[2]), .MEM_signal_o(mem_o[2]), .WB_signal_o(wb_o[2]),
        .valid_o(v_o[2]), .bubble_o(b_o[2]), .flush_busy_o(busy_o[2]), .bubble_cnt_o(cnt2)
    );

    assign obs[0] = {ex_o[0], mem_o[0], wb_o[0], v_o[0], b_o[0], busy_o[0], cnt0};
    assign obs[1] = {ex_o[1], mem_o[1], wb_o[1], v_o[1], b_o[1], busy_o[1], cnt1};
    assign obs[2] = {ex_o[2], mem_o[2], wb_o[2], v_o[2], b_o[2], busy_o[2], 14'd0, cnt2};

    // Reference model: rem = bubble cycles still owed to the latest flush.
    int unsigned fc_p [3] = '{1, 3, 3};
    int unsigned sm_p [3] = '{0, 1, 0};
    int unsigned cmax [3] = '{65535, 65535, 3};
    int unsigned rem  [3];
    int unsigned m_cnt[3];
    logic [1:0]  m_ex [3];
    logic [2:0]  m_mem[3];
    logic [1:0]  m_wb [3];
    logic        m_v  [3];
    logic        m_b  [3];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0; m_cnt[k] = 0; m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
            m_v[k] = 1'b0; m_b[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(int k);
        logic bub;
        bub = 1'b0;
        if (flush_i) rem[k] = fc_p[k];
        if (rem[k] > 0) begin
            bub = 1'b1;
            rem[k] = rem[k] - 1;
        end else if (stall_i) begin
            bub = (sm_p[k] == 0);
        end else begin
            m_ex[k] = ex_i; m_mem[k] = mem_i; m_wb[k] = wb_i; m_v[k] = valid_i; m_b[k] = 1'b0;
        end
        if (bub) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_v[k] = 1'b0; m_b[k] = 1'b1;
            if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        end
    endfunction

    function automatic logic [25:0] exp_vec(int k);
        return {m_ex[k], m_mem[k], m_wb[k], m_v[k], m_b[k], rem[k] > 0, 16'(m_cnt[k])};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
    endtask

    task automatic drive(logic st, logic fl, logic v, logic [1:0] e, logic [2:0] m,
                         logic [1:0] w);
        stall_i = st; flush_i = fl; valid_i = v; ex_i = e; mem_i = m; wb_i = w;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_init[%0d]: got %h want 0", k, obs[k]);
            end
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        drive(1'b0, 1'b1, 1'b1, 2'b11, 3'b111, 2'b01);
        tick();
        drive(1'b0, 1'b0, 1'b1, 2'b11, 3'b111, 2'b01);
        tick();
        // Instance 0 now carries live data, the others are mid-flush with a nonzero count.
        #3;
        rst_i = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_async[%0d]: got %h want 0", k, obs[k]);
            end
        end
        #2;
        rst_i = 1'b0;
    endtask

    task automatic test_normal();
        reset_dut();
        drive(1'b0, 1'b0, 1'b1, 2'b10, 3'b101, 2'b11);
        tick();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL normal[%0d]: got %h want %h", k, obs[k], exp_vec(k));
            end
        end
        n_checks++;
        if (obs[0] !== {2'b10, 3'b101, 2'b11, 1'b1, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL normal_const: got %h want %h", obs[0],
                     {2'b10, 3'b101, 2'b11, 3'b100, 16'd0});
        end
    endtask

    task automatic test_stall_bubble();
        reset_dut();
        drive(1'b0, 1'b0, 1'b1, 2'b10, 3'b101, 2'b11);
        tick();
        drive(1'b1, 1'b0, 1'b1, 2'b11, 3'b011, 2'b10);
        tick();
        n_checks++;
        if (obs[0] !== {7'd0, 1'b0, 1'b1, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL stall_bubble: got %h want %h", obs[0], {10'b0000000010, 16'd1});
        end
        drive(1'b0, 1'b0, 1'b1, 2'b11, 3'b011, 2'b10);
        tick();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL stall_resume[%0d]: got %h want %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_stall_hold();
        reset_dut();
        drive(1'b0, 1'b0, 1'b1, 2'b01, 3'b010, 2'b01);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b1, 2'b10, 3'b111, 2'b10);
            tick();
            n_checks++;
            if (ex_o[1] !== 2'b01 || v_o[1] !== 1'b1 || b_o[1] !== 1'b0 || cnt1 !== 16'd0) begin
                n_fail++;
                $display("FAIL stall_hold c%0d: got ex=%b v=%b b=%b cnt=%0d want ex=01 v=1 b=0 cnt=0",
                         c, ex_o[1], v_o[1], b_o[1], cnt1);
            end
        end
    endtask

    task automatic test_multi_flush();
        logic [2:0] busy_seen;
        logic [2:0] bub_seen;
        reset_dut();
        drive(1'b0, 1'b0, 1'b1, 2'b11, 3'b100, 2'b01);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(c == 1, c == 0, 1'b1, 2'b10, 3'b001, 2'b11);
            tick();
            bub_seen[c % 3] = b_o[1];
            busy_seen[c % 3] = busy_o[1];
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL flush c%0d[%0d]: got %h want %h", c, k, obs[k], exp_vec(k));
                end
            end
            if (c == 2) begin
                n_checks++;
                if (bub_seen !== 3'b111 || busy_seen !== 3'b011 || cnt1 !== 16'd3) begin
                    n_fail++;
                    $display("FAIL flush_window: got bub=%b busy=%b cnt=%0d want 111 011 3",
                             bub_seen, busy_seen, cnt1);
                end
            end
        end
        n_checks++;
        if (b_o[1] !== 1'b0 || ex_o[1] !== 2'b10 || v_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_exit: got b=%b ex=%b v=%b want b=0 ex=10 v=1",
                     b_o[1], ex_o[1], v_o[1]);
        end
    endtask

    task automatic test_reload_sat();
        int nbub;
        nbub = 0;
        reset_dut();
        for (int t = 0; t < 6; t++) begin
            drive(1'b0, (t == 0) || (t == 2), 1'b1, 2'b01, 3'b110, 2'b10);
            tick();
            if (b_o[2] === 1'b1) nbub++;
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL reload t%0d[%0d]: got %h want %h", t, k, obs[k], exp_vec(k));
                end
            end
        end
        n_checks++;
        if (nbub != 5 || cnt2 !== 2'd3 || cnt1 !== 16'd5) begin
            n_fail++;
            $display("FAIL reload_sat: got bubbles=%0d cnt2=%0d cnt1=%0d want 5 3 5",
                     nbub, cnt2, cnt1);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 1'($urandom),
                  2'($urandom), 3'($urandom), 2'($urandom));
            tick();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random c%0d[%0d]: got %h want %h", c, k, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_normal();
        test_stall_bubble();
        test_stall_hold();
        test_multi_flush();
        test_reload_sat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
